mem_access: RTL and testbench

- MEM stage of the 5-stage pipeline. It sits directly downstream of the EX stage and consumes the EX/MEM register contents: ALU result or address, store data, destination register and control bits.
- Memory ops run on a data-memory bus with a req/ack handshake and a variable number of wait states. While an access is in flight the block stalls the upstream pipeline.
- Results are registered into the MEM/WB boundary. Misaligned-address and bus-timeout errors are flagged.

---
 rtl/mem_access.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: MEM stage of the 5-stage pipeline.
// Takes the EX/MEM register contents. ALU-only instructions pass straight
// to the MEM/WB register. Aligned loads and stores run one data-memory bus
// transaction over a req/ack handshake, which may take any number of wait
// states; the upstream pipeline is stalled while that transaction is open.
// A misaligned memory op retires at once with align_err and makes no bus
// access. If no ack arrives within TIMEOUT cycles the access is dropped and
// bus_err is raised.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid, alu_out,        EX/MEM register contents: valid flag,
//   rfile_rd2, MemRead,       ALU result or byte address, store data,
//   MemWrite, MemtoReg,       control bits and destination register
//   RegWrite, wr_reg
//   stall                     upstream must hold EX/MEM and earlier stages
//   mem_req, mem_we,          data-memory bus request side
//   mem_addr, mem_wdata
//   mem_rdata, mem_ack        data-memory bus response side
//   wb_valid, wb_data,        MEM/WB register
//   wb_reg, wb_RegWrite
//   align_err, bus_err        one-cycle error pulses
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] alu_out,
    input  logic [31:0] rfile_rd2,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    input  logic [4:0]  wr_reg,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_RegWrite,
    output logic        align_err,
    output logic        bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        m2r_q, m2r_d;
    logic        rw_q, rw_d;
    logic [4:0]  reg_q, reg_d;
    logic        wbv_q, wbv_d;
    logic [31:0] wbd_q, wbd_d;
    logic [4:0]  wbr_q, wbr_d;
    logic        wbrw_q, wbrw_d;
    logic        aerr_q, aerr_d;
    logic        berr_q, berr_d;
    logic        stall_c;

    logic memop, aligned, timeout;
    assign memop   = in_valid & (MemRead | MemWrite);
    assign aligned = (alu_out[1:0] == 2'b00);
    assign timeout = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        m2r_d   = m2r_q;
        rw_d    = rw_q;
        reg_d   = reg_q;
        wbv_d   = wbv_q;
        wbd_d   = wbd_q;
        wbr_d   = wbr_q;
        wbrw_d  = wbrw_q;
        aerr_d  = 1'b0;
        berr_d  = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (!in_valid) begin
                    wbv_d  = 1'b0;
                    wbrw_d = 1'b0;
                end else if (!memop) begin
                    wbv_d  = 1'b1;
                    wbd_d  = alu_out;
                    wbr_d  = wr_reg;
                    wbrw_d = RegWrite;
                end else if (!aligned) begin
                    wbv_d  = 1'b1;
                    wbd_d  = alu_out;
                    wbr_d  = wr_reg;
                    wbrw_d = 1'b0;
                    aerr_d = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    state_d = BUSY;
                    cnt_d   = 8'd0;
                    req_d   = 1'b1;
                    we_d    = MemWrite;
                    addr_d  = alu_out;
                    wdata_d = rfile_rd2;
                    // Read+write together behaves as a store: never load, never write back.
                    rd_d    = MemRead & ~MemWrite;
                    m2r_d   = MemtoReg;
                    rw_d    = RegWrite & ~MemWrite;
                    reg_d   = wr_reg;
                    wbv_d   = 1'b0;
                    wbrw_d  = 1'b0;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wbv_d   = 1'b1;
                    wbr_d   = reg_q;
                    wbd_d   = (rd_q & m2r_q) ? mem_rdata : addr_q;
                    wbrw_d  = rw_q;
                end else if (timeout) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    wbv_d   = 1'b1;
                    wbr_d   = reg_q;
                    wbd_d   = addr_q;
                    wbrw_d  = 1'b0;
                    berr_d  = 1'b1;
                end else begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            m2r_q   <= 1'b0;
            rw_q    <= 1'b0;
            reg_q   <= 5'd0;
            wbv_q   <= 1'b0;
            wbd_q   <= 32'd0;
            wbr_q   <= 5'd0;
            wbrw_q  <= 1'b0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            m2r_q   <= m2r_d;
            rw_q    <= rw_d;
            reg_q   <= reg_d;
            wbv_q   <= wbv_d;
            wbd_q   <= wbd_d;
            wbr_q   <= wbr_d;
            wbrw_q  <= wbrw_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    // Reset keeps stall low even if upstream still presents a memory op.
    assign stall       = stall_c & ~rst;
    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign wb_valid    = wbv_q;
    assign wb_data     = wbd_q;
    assign wb_reg      = wbr_q;
    assign wb_RegWrite = wbrw_q;
    assign align_err   = aerr_q;
    assign bus_err     = berr_q;

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] alu_out;
    logic [31:0] rfile_rd2;
    logic        MemRead, MemWrite, MemtoReg, RegWrite;
    logic [4:0]  wr_reg;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_RegWrite, align_err, bus_err;

    mem_access #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_out(alu_out),
        .rfile_rd2(rfile_rd2), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .wr_reg(wr_reg),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_reg(wb_reg), .wb_RegWrite(wb_RegWrite), .align_err(align_err),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rg;
        logic        rw;
        logic        ae;
        logic        be;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard monitor: every MEM/WB retirement is matched against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL wb_unexpected: got data 0x%08h reg %0d with empty queue at %0t",
                             wb_data, wb_reg, $time);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    chk("wb_data", wb_data, e.data);
                    chk("wb_reg", 32'(wb_reg), 32'(e.rg));
                    chk("wb_RegWrite", 32'(wb_RegWrite), 32'(e.rw));
                    chk("align_err", 32'(align_err), 32'(e.ae));
                    chk("bus_err", 32'(bus_err), 32'(e.be));
                end
            end else begin
                chk("bubble_quiet", 32'({wb_RegWrite, align_err, bus_err}), 32'd0);
            end
        end
    end

    task automatic idle_in();
        in_valid = 0; alu_out = 0; rfile_rd2 = 0;
        MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0; wr_reg = 0;
    endtask

    task automatic present(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                           input logic wr, input logic m2r, input logic rw, input logic [4:0] rg);
        in_valid = 1; alu_out = a; rfile_rd2 = wd;
        MemRead = rd; MemWrite = wr; MemtoReg = m2r; RegWrite = rw; wr_reg = rg;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Presents an aligned memory op, holds it for `waits` unacked BUSY cycles,
    // then spends one last BUSY cycle with mem_ack = ack.
    task automatic mem_op(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                          input logic wr, input logic m2r, input logic rw, input logic [4:0] rg,
                          input int waits, input logic ack, input logic [31:0] rdata);
        present(a, wd, rd, wr, m2r, rw, rg);
        @(negedge clk);
        chk("issue_stall", 32'(stall), 32'd1);
        chk("issue_req", 32'(mem_req), 32'd0);
        step();
        alu_out = ~a; rfile_rd2 = ~wd;   // must be ignored while BUSY
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("busy_req", 32'(mem_req), 32'd1);
            chk("busy_addr", mem_addr, a);
            chk("busy_we", 32'(mem_we), 32'(wr));
            chk("busy_wdata", mem_wdata, wd);
            chk("busy_stall", 32'(stall), 32'd1);
            step();
        end
        mem_ack = ack; mem_rdata = rdata;
        @(negedge clk);
        chk("last_stall", 32'(stall), 32'd0);
        chk("last_req", 32'(mem_req), 32'd1);
        chk("last_addr", mem_addr, a);
        step();
        mem_ack = 0; mem_rdata = 0;
        idle_in();
        chk("req_drop", 32'(mem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1; mem_ack = 0; mem_rdata = 0;
        idle_in();
        #12;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_outs", 32'({mem_we, wb_valid, wb_RegWrite, align_err, bus_err, stall}), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);
        rst = 0;
        step();

        // ALU op
        present(32'h0000_1234, 32'h0, 0, 0, 0, 1, 5'd5);
        exp_q.push_back('{32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0});
        @(negedge clk); chk("alu_stall", 32'(stall), 32'd0);
        step(); idle_in();

        // Ack while IDLE must be ignored
        mem_ack = 1; mem_rdata = 32'h5555_5555;
        step(); mem_ack = 0; mem_rdata = 0;
        step();

        // Load 0x100, 3 wait cycles
        exp_q.push_back('{32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, 1'b0});
        mem_op(32'h100, 32'h0, 1, 0, 1, 1, 5'd8, 3, 1'b1, 32'hDEAD_BEEF);
        step();

        // Store with zero waits, next instruction accepted right after the ack edge
        exp_q.push_back('{32'h0000_0204, 5'd3, 1'b0, 1'b0, 1'b0});
        mem_op(32'h204, 32'hCAFE_F00D, 0, 1, 0, 1, 5'd3, 0, 1'b1, 32'h0);
        present(32'h0000_0777, 32'h0, 0, 0, 0, 1, 5'd7);
        exp_q.push_back('{32'h0000_0777, 5'd7, 1'b1, 1'b0, 1'b0});
        @(negedge clk); chk("post_store_stall", 32'(stall), 32'd0);
        step(); idle_in();
        step();

        // Misaligned load
        present(32'h102, 32'h0, 1, 0, 1, 1, 5'd4);
        exp_q.push_back('{32'h0000_0102, 5'd4, 1'b0, 1'b1, 1'b0});
        @(negedge clk);
        chk("misal_stall", 32'(stall), 32'd0);
        chk("misal_req", 32'(mem_req), 32'd0);
        step(); idle_in();
        @(negedge clk); chk("misal_no_req", 32'(mem_req), 32'd0);
        step();

        // Timeout: 15 stalled cycles, stall drops in the 16th, no ack
        exp_q.push_back('{32'h0000_0400, 5'd9, 1'b0, 1'b0, 1'b1});
        mem_op(32'h400, 32'h0, 1, 0, 1, 1, 5'd9, 15, 1'b0, 32'h0);
        step();

        // Same, but ack arrives in the timeout cycle
        exp_q.push_back('{32'h1234_5678, 5'd9, 1'b1, 1'b0, 1'b0});
        mem_op(32'h400, 32'h0, 1, 0, 1, 1, 5'd9, 15, 1'b1, 32'h1234_5678);
        step();

        // Reset in the middle of a BUSY wait
        present(32'h300, 32'h0, 1, 0, 1, 1, 5'd6);
        step(); step();
        #2 rst = 1;
        #1;
        chk("midrst_req", 32'(mem_req), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        chk("midrst_wbv", 32'(wb_valid), 32'd0);
        idle_in();
        @(negedge clk); rst = 0;
        step();
        present(32'h0000_00AB, 32'h0, 0, 0, 0, 1, 5'd11);
        exp_q.push_back('{32'h0000_00AB, 5'd11, 1'b1, 1'b0, 1'b0});
        step(); idle_in();
        step(); step();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
